dmem_responder: RTL and testbench

//  Data-memory responder serving the load/store requests the MEM stage issues
//  (address = opr_res, store data = opr_b, write enable from dm_en).

---
 rtl/dmem_responder.sv | 128 ++++++++++++
 tb/tb_dmem_responder.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Word-organised data-memory responder with byte enables and a fixed wait-state
// count between request acceptance and the single-cycle response.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        arst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0]  CNT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_we;
    logic [29:0] r_waddr;
    logic [31:0] r_wdata;
    logic [3:0]  r_be;
    logic [31:0] r_rdata;
    logic        r_err;
    logic [31:0] r_mem [DEPTH_WORDS];

    logic        w_accept;
    logic        w_direct;
    logic        w_wait_done;
    logic        w_commit;
    logic        w_c_we;
    logic [29:0] w_c_waddr;
    logic [31:0] w_c_wdata;
    logic [3:0]  w_c_be;
    logic [29:0] w_off;
    logic        w_fault;
    logic [AW-1:0] w_idx;
    logic [31:0] w_old;
    logic [31:0] w_merged;
    logic        w_unused;

    assign req_ready = (r_state != S_WAIT);
    assign rsp_valid = (r_state == S_RESP);
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;
    assign w_unused  = |req_addr[1:0];

    assign w_accept    = req_valid && req_ready;
    // With no wait states the memory action happens on the accept edge itself,
    // so the live request is used instead of the latched copy.
    assign w_direct    = w_accept && (WAIT_STATES == 0);
    assign w_wait_done = (r_state == S_WAIT) && (r_cnt == 4'd0);
    assign w_commit    = w_direct || w_wait_done;

    assign w_c_we    = w_direct ? req_we         : r_we;
    assign w_c_waddr = w_direct ? req_addr[31:2] : r_waddr;
    assign w_c_wdata = w_direct ? req_wdata      : r_wdata;
    assign w_c_be    = w_direct ? req_be         : r_be;

    // Word offset is modular, so addresses below the base wrap high and fault.
    assign w_off   = w_c_waddr - BASE_ADDR[31:2];
    assign w_fault = (w_off >= 30'(DEPTH_WORDS)) || (w_c_we && (w_c_be == 4'b0000));
    assign w_idx   = w_off[AW-1:0];
    assign w_old   = r_mem[w_idx];

    always_comb begin
        w_merged = w_old;
        for (int i = 0; i < 4; i++) begin
            if (w_c_be[i]) begin
                w_merged[8*i +: 8] = w_c_wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_commit && w_c_we && !w_fault) begin
            r_mem[w_idx] <= w_merged;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
            r_be    <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_commit) begin
                r_err   <= w_fault;
                r_rdata <= (!w_c_we && !w_fault) ? w_old : 32'd0;
            end
            if (w_accept) begin
                r_we    <= req_we;
                r_waddr <= req_addr[31:2];
                r_wdata <= req_wdata;
                r_be    <= req_be;
                r_cnt   <= CNT_INIT;
                r_state <= (WAIT_STATES == 0) ? S_RESP : S_WAIT;
            end else begin
                case (r_state)
                    S_WAIT: begin
                        if (r_cnt == 4'd0) begin
                            r_state <= S_RESP;
                        end else begin
                            r_cnt <= r_cnt - 4'd1;
                        end
                    end
                    S_RESP:  r_state <= S_IDLE;
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances with 1, 0 and 3 wait states
// share the request bus; each has its own req_valid and response outputs.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        arst_n;
    logic [2:0]  vin;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [2:0]  rdy;
    logic [2:0]  rspv;
    logic [2:0]  err;
    logic [31:0] rd [3];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_STATES(1)) u_ws1 (
        .clk(clk), .arst_n(arst_n), .req_valid(vin[0]), .req_ready(rdy[0]),
        .req_we(we), .req_addr(addr), .req_wdata(wdata), .req_be(be),
        .rsp_valid(rspv[0]), .rsp_rdata(rd[0]), .rsp_err(err[0])
    );

    dmem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_STATES(0)) u_ws0 (
        .clk(clk), .arst_n(arst_n), .req_valid(vin[1]), .req_ready(rdy[1]),
        .req_we(we), .req_addr(addr), .req_wdata(wdata), .req_be(be),
        .rsp_valid(rspv[1]), .rsp_rdata(rd[1]), .rsp_err(err[1])
    );

    dmem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_STATES(3)) u_ws3 (
        .clk(clk), .arst_n(arst_n), .req_valid(vin[2]), .req_ready(rdy[2]),
        .req_we(we), .req_addr(addr), .req_wdata(wdata), .req_be(be),
        .rsp_valid(rspv[2]), .rsp_rdata(rd[2]), .rsp_err(err[2])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One isolated request on instance k; checks latency, data, error and the
    // single-cycle width of rsp_valid.
    task automatic xfer(input int k, input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] b, input int ws, input logic [31:0] exp_rd,
                        input logic exp_err, input string tag);
        int lat;
        @(negedge clk);
        chk({tag, "_ready"}, 32'(rdy[k]), 32'd1);
        vin[k] = 1'b1; we = w; addr = a; wdata = d; be = b;
        @(posedge clk); #1;
        vin[k] = 1'b0;
        lat = 1;
        while (!rspv[k] && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_lat"}, 32'(lat), 32'(ws + 1));
        chk({tag, "_rdata"}, rd[k], exp_rd);
        chk({tag, "_err"}, 32'(err[k]), 32'(exp_err));
        @(posedge clk); #1;
        chk({tag, "_vld1cyc"}, 32'(rspv[k]), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        arst_n = 1'b0; vin = '0; we = 1'b0; addr = '0; wdata = '0; be = '0;
        #12;
        for (int k = 0; k < 3; k++) begin
            chk("rst_ready", 32'(rdy[k]), 32'd1);
            chk("rst_rspv", 32'(rspv[k]), 32'd0);
            chk("rst_rdata", rd[k], 32'd0);
            chk("rst_err", 32'(err[k]), 32'd0);
        end
        @(negedge clk);
        arst_n = 1'b1;

        // Basic store/load with one wait state
        xfer(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 1, 32'h0, 1'b0, "t1_st");
        xfer(0, 1'b0, 32'h10, 32'h0, 4'hF, 1, 32'hDEAD_BEEF, 1'b0, "t1_ld");

        // Byte enables; load with be=0000 is not a fault
        xfer(0, 1'b1, 32'h20, 32'h1122_3344, 4'hF, 1, 32'h0, 1'b0, "t2_init");
        xfer(0, 1'b1, 32'h22, 32'hAABB_CCDD, 4'b0101, 1, 32'h0, 1'b0, "t2_st");
        xfer(0, 1'b0, 32'h20, 32'h0, 4'b0000, 1, 32'h11BB_33DD, 1'b0, "t2_ld");

        // Faults and the last valid word
        xfer(0, 1'b0, 32'h1000, 32'h0, 4'hF, 1, 32'h0, 1'b1, "t4_oob");
        xfer(0, 1'b1, 32'h10, 32'h1234_5678, 4'h0, 1, 32'h0, 1'b1, "t4_be0");
        xfer(0, 1'b0, 32'h10, 32'h0, 4'hF, 1, 32'hDEAD_BEEF, 1'b0, "t4_unch");
        xfer(0, 1'b0, 32'hFFFF_FFFC, 32'h0, 4'hF, 1, 32'h0, 1'b1, "t4_below");
        xfer(0, 1'b1, 32'hFFC, 32'hCAFE_F00D, 4'hF, 1, 32'h0, 1'b0, "t4_last_st");
        xfer(0, 1'b0, 32'hFFC, 32'h0, 4'hF, 1, 32'hCAFE_F00D, 1'b0, "t4_last_ld");

        // Zero wait states: store then load accepted back to back
        @(negedge clk);
        vin[1] = 1'b1; we = 1'b1; addr = 32'h40; wdata = 32'h600D_F00D; be = 4'hF;
        @(posedge clk); #1;
        chk("t3_st_v", 32'(rspv[1]), 32'd1);
        chk("t3_st_err", 32'(err[1]), 32'd0);
        @(negedge clk);
        chk("t3_ready_resp", 32'(rdy[1]), 32'd1);
        we = 1'b0; wdata = 32'h0;
        @(posedge clk); #1;
        chk("t3_ld_v", 32'(rspv[1]), 32'd1);
        chk("t3_ld_rdata", rd[1], 32'h600D_F00D);
        @(negedge clk);
        vin[1] = 1'b0;
        @(posedge clk); #1;
        chk("t3_idle", 32'(rspv[1]), 32'd0);

        // Reset during a pending store drops it
        xfer(2, 1'b1, 32'h8, 32'h0102_0304, 4'hF, 3, 32'h0, 1'b0, "t5_pre");
        @(negedge clk);
        vin[2] = 1'b1; we = 1'b1; addr = 32'h8; wdata = 32'hFFFF_FFFF; be = 4'hF;
        @(posedge clk); #1;
        vin[2] = 1'b0;
        chk("t5_in_wait", 32'(rdy[2]), 32'd0);
        @(negedge clk);
        arst_n = 1'b0;
        #1;
        chk("t5_rst_ready", 32'(rdy[2]), 32'd1);
        chk("t5_rst_rspv", 32'(rspv[2]), 32'd0);
        @(negedge clk);
        arst_n = 1'b1;
        seen = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (rspv[2]) seen++;
        end
        chk("t5_no_rsp", 32'(seen), 32'd0);
        xfer(2, 1'b0, 32'h8, 32'h0, 4'hF, 3, 32'h0102_0304, 1'b0, "t5_ld");

        // Request bus changes while in WAIT are ignored
        xfer(2, 1'b1, 32'h10, 32'h0000_0055, 4'hF, 3, 32'h0, 1'b0, "t6_pre");
        @(negedge clk);
        vin[2] = 1'b1; we = 1'b0; addr = 32'h8; wdata = 32'h0; be = 4'hF;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            we = 1'b1; addr = 32'h10; wdata = 32'hBAD0_0000 + 32'(i); be = 4'hF;
            chk("t6_wait_ready", 32'(rdy[2]), 32'd0);
        end
        @(posedge clk); #1;
        chk("t6_rspv", 32'(rspv[2]), 32'd1);
        chk("t6_rdata", rd[2], 32'h0102_0304);
        chk("t6_err", 32'(err[2]), 32'd0);
        @(negedge clk);
        vin[2] = 1'b0;
        @(posedge clk); #1;
        chk("t6_idle", 32'(rspv[2]), 32'd0);
        xfer(2, 1'b0, 32'h10, 32'h0, 4'hF, 3, 32'h0000_0055, 1'b0, "t6_ld");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
